// File: rtl/led_seq_driver.sv
// LED bank pattern sequencer: step prescaler, mode handshake, pattern FSM and PWM dimming.
// Optional macro LED_SEQ_GAMMA_EN squares the brightness threshold through one register stage.
module led_seq_driver #(
    parameter int CLK_HZ   = 50_000_000,
    parameter int STEP_HZ  = 4,
    parameter int PWM_BITS = 8,
    parameter int NUM_LEDS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [1:0]          mode,
    input  logic                mode_valid,
    output logic                mode_ready,
    input  logic [PWM_BITS-1:0] brightness,
    output logic                step_tick,
    output logic [NUM_LEDS-1:0] led
);

    localparam int DIV   = CLK_HZ / STEP_HZ;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    localparam logic [1:0] MODE_OFF    = 2'd0;
    localparam logic [1:0] MODE_CHASE  = 2'd1;
    localparam logic [1:0] MODE_BOUNCE = 2'd2;
    localparam logic [1:0] MODE_BLINK  = 2'd3;

    localparam logic [2:0] ST_OFF       = 3'd0;
    localparam logic [2:0] ST_CHASE     = 3'd1;
    localparam logic [2:0] ST_BOUNCE_UP = 3'd2;
    localparam logic [2:0] ST_BOUNCE_DN = 3'd3;
    localparam logic [2:0] ST_BLINK     = 3'd4;

    localparam logic [NUM_LEDS-1:0] PAT_ONE = {{(NUM_LEDS-1){1'b0}}, 1'b1};
    localparam logic [NUM_LEDS-1:0] PAT_ALL = {NUM_LEDS{1'b1}};

    generate
        if (DIV < 2) begin : g_bad_div
            $error("led_seq_driver: CLK_HZ/STEP_HZ must be at least 2");
        end
        if (NUM_LEDS < 2) begin : g_bad_leds
            $error("led_seq_driver: NUM_LEDS must be at least 2");
        end
    endgenerate

    // ---------------- step prescaler ----------------
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick;

    assign tick      = en && (cnt_q == CNT_MAX);
    assign step_tick = tick;

    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // ---------------- mode handshake ----------------
    // pend_q is still 0 in the transfer cycle, so a tick there cannot apply the new mode.
    logic       pend_q, pend_d;
    logic [1:0] pmode_q, pmode_d;
    logic       accept, apply;

    assign mode_ready = !pend_q;
    assign accept     = mode_valid && !pend_q;
    assign apply      = tick && pend_q;

    always_comb begin
        pend_d  = pend_q;
        pmode_d = pmode_q;
        if (apply) begin
            pend_d = 1'b0;
        end
        if (accept) begin
            pend_d  = 1'b1;
            pmode_d = mode;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q  <= 1'b0;
            pmode_q <= MODE_OFF;
        end else begin
            pend_q  <= pend_d;
            pmode_q <= pmode_d;
        end
    end

    // ---------------- pattern FSM ----------------
    logic [2:0]          state_q, state_d;
    logic [NUM_LEDS-1:0] pat_q, pat_d;

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        if (apply) begin
            // An applied mode restarts its pattern and does not advance on this tick.
            case (pmode_q)
                MODE_CHASE: begin
                    state_d = ST_CHASE;
                    pat_d   = PAT_ONE;
                end
                MODE_BOUNCE: begin
                    state_d = ST_BOUNCE_UP;
                    pat_d   = PAT_ONE;
                end
                MODE_BLINK: begin
                    state_d = ST_BLINK;
                    pat_d   = PAT_ALL;
                end
                default: begin
                    state_d = ST_OFF;
                    pat_d   = '0;
                end
            endcase
        end else if (tick) begin
            case (state_q)
                ST_CHASE: begin
                    pat_d = {pat_q[NUM_LEDS-2:0], pat_q[NUM_LEDS-1]};
                end
                ST_BOUNCE_UP: begin
                    pat_d = pat_q << 1;
                    if (pat_d[NUM_LEDS-1]) begin
                        state_d = ST_BOUNCE_DN;
                    end
                end
                ST_BOUNCE_DN: begin
                    pat_d = pat_q >> 1;
                    if (pat_d[0]) begin
                        state_d = ST_BOUNCE_UP;
                    end
                end
                ST_BLINK: begin
                    pat_d = ~pat_q;
                end
                default: begin
                    state_d = ST_OFF;
                    pat_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_OFF;
            pat_q   <= '0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
        end
    end

    // ---------------- PWM ----------------
    logic [PWM_BITS-1:0] pwm_q;
    logic [PWM_BITS-1:0] thr;
    logic                full;
    logic                duty_on;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_q <= '0;
        end else begin
            pwm_q <= pwm_q + 1'b1;
        end
    end

`ifdef LED_SEQ_GAMMA_EN
    logic [2*PWM_BITS-1:0] sq;
    logic [PWM_BITS-1:0]   thr_q;
    logic                  full_q;

    assign sq = {{PWM_BITS{1'b0}}, brightness} * {{PWM_BITS{1'b0}}, brightness};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            thr_q  <= '0;
            full_q <= 1'b0;
        end else begin
            thr_q  <= PWM_BITS'(sq >> PWM_BITS);
            full_q <= &brightness;
        end
    end

    assign thr  = thr_q;
    assign full = full_q;
`else
    assign thr  = brightness;
    assign full = &brightness;
`endif

    // All-ones brightness must be fully on; the compare alone would drop one cycle per period.
    assign duty_on = full || (pwm_q < thr);

    // ---------------- output register ----------------
    logic [NUM_LEDS-1:0] led_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_q <= '0;
        end else begin
            led_q <= pat_q & {NUM_LEDS{duty_on}};
        end
    end

    assign led = led_q;

endmodule

// File: tb/tb_led_seq_driver.sv
// Directed self-checking bench for led_seq_driver with DIV=10, 4 LEDs, 8-bit PWM.
module tb_led_seq_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic       mode_valid;
    logic       mode_ready;
    logic [7:0] brightness;
    logic       step_tick;
    logic [3:0] led;

    int checks   = 0;
    int failures = 0;

    led_seq_driver #(
        .CLK_HZ  (40),
        .STEP_HZ (4),
        .PWM_BITS(8),
        .NUM_LEDS(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .mode_valid(mode_valid),
        .mode_ready(mode_ready),
        .brightness(brightness),
        .step_tick (step_tick),
        .led       (led)
    );

    always #5 clk = ~clk;

    // Advance to the negedge on which step_tick is high (checks the current one first).
    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (step_tick === 1'b1) ok = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic send_mode(input logic [1:0] m);
        mode       = m;
        mode_valid = 1'b1;
        @(negedge clk);
        mode_valid = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if (led !== 4'b0000 || mode_ready !== 1'b1 || step_tick !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: led=%b ready=%b tick=%b, need led=0000 ready=1 tick=0",
                     led, mode_ready, step_tick);
        end
        rst = 1'b0;
    endtask

    // Ticks at 9 and 19 after release; en low for 5 cycles from cycle 22 pushes the next one to 34.
    task automatic test_tick;
        for (int k = 0; k <= 40; k++) begin
            logic exp;
            en  = !(k >= 22 && k < 27);
            exp = (k == 9) || (k == 19) || (k == 34);
            checks++;
            if (step_tick !== exp) begin
                failures++;
                $display("FAIL tick_period: cycle %0d step_tick=%b, need %b", k, step_tick, exp);
            end
            @(negedge clk);
        end
        en = 1'b1;
    endtask

    task automatic test_chase;
        logic [3:0] exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        bit ok;
        brightness = 8'hFF;
        send_mode(2'd1);
        checks++;
        if (mode_ready !== 1'b0) begin
            failures++;
            $display("FAIL chase_ready_low: mode_ready=%b, need 0", mode_ready);
        end
        for (int i = 0; i < 5; i++) begin
            wait_tick(ok);
            repeat (2) @(negedge clk);
            checks++;
            if (!ok || led !== exp[i]) begin
                failures++;
                $display("FAIL chase_step%0d: led=%b tick_seen=%0d, need %b", i, led, ok, exp[i]);
            end
        end
    endtask

    task automatic test_bounce;
        logic [3:0] exp [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                4'b0100, 4'b0010, 4'b0001, 4'b0010};
        bit ok;
        send_mode(2'd2);
        for (int i = 0; i < 8; i++) begin
            wait_tick(ok);
            repeat (2) @(negedge clk);
            checks++;
            if (!ok || led !== exp[i]) begin
                failures++;
                $display("FAIL bounce_step%0d: led=%b tick_seen=%0d, need %b", i, led, ok, exp[i]);
            end
        end
    endtask

    // Re-requesting the running mode restarts it at its first step.
    task automatic test_restart;
        bit ok;
        send_mode(2'd1);
        wait_tick(ok);
        repeat (2) @(negedge clk);
        wait_tick(ok);
        repeat (2) @(negedge clk);
        checks++;
        if (!ok || led !== 4'b0010) begin
            failures++;
            $display("FAIL restart_pre: led=%b, need 0010", led);
        end
        send_mode(2'd1);
        wait_tick(ok);
        repeat (2) @(negedge clk);
        checks++;
        if (!ok || led !== 4'b0001) begin
            failures++;
            $display("FAIL restart_apply: led=%b, need 0001", led);
        end
    endtask

    task automatic test_handshake;
        bit ok;
        bit bad;
        checks++;
        if (mode_ready !== 1'b1) begin
            failures++;
            $display("FAIL hs_ready_idle: mode_ready=%b, need 1", mode_ready);
        end
        mode       = 2'd3;
        mode_valid = 1'b1;
        @(negedge clk);
        mode = 2'd1;
        ok   = 1'b0;
        bad  = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (mode_ready !== 1'b0) bad = 1'b1;
            if (step_tick === 1'b1) ok = 1'b1;
            else @(negedge clk);
        end
        mode_valid = 1'b0;
        checks++;
        if (!ok || bad) begin
            failures++;
            $display("FAIL hs_ready_pending: ready_went_high=%0d tick_seen=%0d, need 0 and 1", bad, ok);
        end
        @(negedge clk);
        checks++;
        if (mode_ready !== 1'b1) begin
            failures++;
            $display("FAIL hs_ready_after_apply: mode_ready=%b, need 1", mode_ready);
        end
        @(negedge clk);
        checks++;
        if (led !== 4'b1111) begin
            failures++;
            $display("FAIL hs_blink_on: led=%b, need 1111", led);
        end
        wait_tick(ok);
        repeat (2) @(negedge clk);
        checks++;
        if (!ok || led !== 4'b0000) begin
            failures++;
            $display("FAIL hs_blink_off: led=%b, need 0000", led);
        end
        wait_tick(ok);
        repeat (2) @(negedge clk);
        checks++;
        if (!ok || led !== 4'b1111) begin
            failures++;
            $display("FAIL hs_no_second_accept: led=%b, need 1111", led);
        end
    endtask

    task automatic test_pwm;
        logic [7:0] bval [5] = '{8'd64, 8'd0, 8'hFF, 8'd128, 8'd1};
`ifdef LED_SEQ_GAMMA_EN
        int         expn [5] = '{16, 0, 256, 64, 0};
`else
        int         expn [5] = '{64, 0, 256, 128, 1};
`endif
        bit ok;
        brightness = 8'hFF;
        send_mode(2'd3);
        wait_tick(ok);
        @(negedge clk);
        en = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL pwm_setup: no tick seen, need one");
        end
        for (int j = 0; j < 5; j++) begin
            int on_cnt;
            int other;
            brightness = bval[j];
            repeat (4) @(negedge clk);
            on_cnt = 0;
            other  = 0;
            for (int c = 0; c < 256; c++) begin
                if (led === 4'b1111) on_cnt++;
                else if (led !== 4'b0000) other++;
                @(negedge clk);
            end
            checks++;
            if (on_cnt != expn[j] || other != 0) begin
                failures++;
                $display("FAIL pwm_duty_b%0d: on=%0d stray=%0d, need on=%0d stray=0",
                         bval[j], on_cnt, other, expn[j]);
            end
        end
        brightness = 8'hFF;
        en         = 1'b1;
    endtask

    task automatic test_midreset;
        bit ok;
        bit bad_led;
        bit bad_tick;
        send_mode(2'd1);
        for (int i = 0; i < 3; i++) begin
            wait_tick(ok);
            repeat (2) @(negedge clk);
        end
        checks++;
        if (!ok || led !== 4'b0100) begin
            failures++;
            $display("FAIL midrst_pre: led=%b, need 0100", led);
        end
        send_mode(2'd3);
        checks++;
        if (mode_ready !== 1'b0) begin
            failures++;
            $display("FAIL midrst_pending: mode_ready=%b, need 0", mode_ready);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (led !== 4'b0000 || mode_ready !== 1'b1) begin
            failures++;
            $display("FAIL midrst_async: led=%b ready=%b, need 0000 and 1", led, mode_ready);
        end
        @(negedge clk);
        rst      = 1'b0;
        bad_led  = 1'b0;
        bad_tick = 1'b0;
        for (int k = 0; k < 32; k++) begin
            if (led !== 4'b0000) bad_led = 1'b1;
            if (step_tick !== ((k % 10) == 9)) bad_tick = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (bad_led) begin
            failures++;
            $display("FAIL midrst_off: led left 0000 after reset, need 0000 throughout");
        end
        checks++;
        if (bad_tick) begin
            failures++;
            $display("FAIL midrst_tick: step_tick not at cycles 9/19/29 after release");
        end
    endtask

    initial begin
        rst        = 1'b1;
        en         = 1'b1;
        mode       = 2'd0;
        mode_valid = 1'b0;
        brightness = 8'hFF;
        test_reset();
        test_tick();
        test_chase();
        test_bounce();
        test_restart();
        test_handshake();
        test_pwm();
        test_midreset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_seq_driver.md
Name: led_seq_driver

Overview:
- Pattern and dimming stage that drives the board LED bank (4 LEDs, 50 MHz clock). It sits directly upstream of the LED pins inside top.
- Generates a slow step tick from the system clock and runs a pattern state machine (off/chase/bounce/blink) on that tick.
- Gates the active pattern with a PWM brightness signal.
- Mode changes arrive over a valid/ready handshake and take effect on step boundaries.

Parameters:
- CLK_HZ, 50_000_000, input clock frequency in Hz.
- STEP_HZ, 4, pattern step rate in Hz. DIV = CLK_HZ/STEP_HZ; DIV must be at least 2.
- PWM_BITS, 8, width of the brightness value and of the PWM counter.
- NUM_LEDS, 4, LED count; must be at least 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- en  in  1  enables the prescaler and pattern advance.
- mode  in  2  requested mode: 0 OFF, 1 CHASE, 2 BOUNCE, 3 BLINK.
- mode_valid  in  1  mode request valid.
- mode_ready  out  1  block can accept a mode request.
- brightness  in  PWM_BITS  PWM duty threshold.
- step_tick  out  1  one-cycle pulse at each pattern step.
- led  out  NUM_LEDS  registered LED drive, active-high.

Behaviour:
- Reset (async assert, sync release):
  - prescaler 0; PWM counter 0.
  - state OFF; pattern all zeros.
  - pending flag 0; mode_ready 1.
  - step_tick 0; led all zeros.
- Prescaler:
  - Counts 0..DIV-1 while en=1, then wraps.
  - step_tick=1 in the cycle the count equals DIV-1 and en=1.
  - When en=0 the count holds, step_tick is 0 and the pattern freezes. PWM and led keep running.
- Handshake:
  - mode_ready = !pending.
  - A transfer happens when mode_valid && mode_ready. The mode is latched into a pending register and pending is set.
  - At the first step_tick strictly after the transfer cycle, the pending mode is applied and pending clears. A tick in the transfer cycle itself does not apply it.
  - On an applying tick the pattern restarts and does not advance.
  - Re-requesting the current mode also restarts the pattern.
- Pattern state machine: states OFF, CHASE, BOUNCE_UP, BOUNCE_DN, BLINK.
  - OFF: pattern 0. Holds until a mode is applied.
  - CHASE: starts at one-hot bit0 and rotates left each tick; bit NUM_LEDS-1 wraps to bit0.
  - BOUNCE: starts at bit0 in BOUNCE_UP and shifts left each tick.
    - Reaching bit NUM_LEDS-1 moves to BOUNCE_DN, which shifts right.
    - Reaching bit0 moves back to BOUNCE_UP.
    - The end LEDs are lit for exactly one step each.
  - BLINK: starts all-ones and inverts each tick.
- PWM:
  - The PWM counter free-runs 0..2^PWM_BITS-1 and wraps.
  - duty_on = (pwm_cnt < brightness).
  - brightness all-ones forces duty_on=1 (full on); brightness 0 gives always off.
- Output: led <= pattern & {NUM_LEDS{duty_on}}, registered. Latency is 1 cycle from a pattern or PWM change to led.
- Brightness is sampled every cycle; changes need no handshake.

Optional Feature:
- Macro: LED_SEQ_GAMMA_EN.
- When defined:
  - The threshold becomes (brightness*brightness) >> PWM_BITS, computed in a register stage.
  - brightness all-ones still forces full on.
  - led latency from a brightness change becomes 2 cycles.
- When undefined: linear threshold, 1-cycle latency.

Test Plan:
- Tick period: CLK_HZ=40, STEP_HZ=4 (DIV=10), en=1 → step_tick pulses every 10 cycles, first at cycle 9 after reset release; en=0 for 5 cycles delays the next tick by 5.
- Chase sequence: brightness=8'hFF, transfer mode=1 → at the first tick after transfer led=0001 one cycle later; subsequent ticks give 0010, 0100, 1000, 0001.
- Bounce sequence: mode=2, full brightness → ticks give 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010.
- Handshake timing:
  - mode=3 transfer → mode_ready=0 until the applying tick, then 1.
  - mode_valid held high with mode=1 during pending is not accepted.
  - After the apply, led=1111 then 0000 on the next tick.
- PWM duty: mode=3 held at the all-ones phase, brightness=64 → led=1111 for exactly 64 of every 256 cycles. brightness=0 → always 0000. With LED_SEQ_GAMMA_EN, brightness=128 → 64 of 256 cycles.
- Reset mid-pattern: assert rst asynchronously mid-chase (led=0100) → led=0000 and mode_ready=1 immediately. After release the state is OFF and led stays 0000 until a new mode is applied.
